lfsr_checker: RTL and testbench



---
 rtl/lfsr_checker_if.sv | 10 +
 rtl/lfsr_checker.sv | 144 ++++++++++++++
 tb/tb_lfsr_checker.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/lfsr_checker_if.sv
// Receive-side handshake bundle for lfsr_checker: the upstream path drives
// valid/data; the checker returns ready.
interface lfsr_checker_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/lfsr_checker.sv
// lfsr_checker: self-synchronising checker for an 8-bit Fibonacci LFSR stream.
// The first accepted word of a run seeds the predictor. Each later word is
// compared against the predicted state, and mismatches are counted over
// seq_num words.
// Optional build macro LFSR_CHK_RESYNC_EN: on the third consecutive mismatch,
// the predictor reloads from the received word.
module lfsr_checker (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2:0]           tap0,
  input  logic [2:0]           tap1,
  input  logic [7:0]           seq_num,
  lfsr_checker_if.slave        in_if,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 lockup,
  output logic [7:0]           err_count
);

  typedef enum logic [1:0] {IDLE, SEED, CHECK, DONE} state_t;

  state_t     state;
  logic [2:0] tap0_q, tap1_q;
  logic [7:0] seq_q;
  logic [7:0] pred;
  logic [7:0] cnt;
`ifdef LFSR_CHK_RESYNC_EN
  logic [1:0] consec;
`endif

  logic       acc;
  logic       mism;
  logic [7:0] err_nxt;
  logic [7:0] cnt_nxt;

  // One shift of the generator with the run's latched taps. Equal taps give a
  // zero feedback bit.
  function automatic logic [7:0] lfsr_next(input logic [7:0] x,
                                           input logic [2:0] a,
                                           input logic [2:0] b);
    return {x[6:0], x[a] ^ x[b]};
  endfunction

  // Handshake status is decoded from registered state only.
  assign in_if.in_ready = (state == SEED) || (state == CHECK);
  assign busy           = (state == SEED) || (state == CHECK);
  assign acc            = in_if.in_valid && in_if.in_ready;

  // Compute the mismatch flag and the next error count (saturating) and word count.
  always_comb begin
    mism    = (in_if.in_data != pred);
    err_nxt = err_count;
    if (mism && (err_count != 8'hFF)) err_nxt = err_count + 8'd1;
    cnt_nxt = cnt + 8'd1;
  end

  // Run sequencer. The pass flag is resolved on entry to DONE so that it is
  // already valid in the cycle that done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tap0_q    <= 3'd0;
      tap1_q    <= 3'd0;
      seq_q     <= 8'd0;
      pred      <= 8'd0;
      cnt       <= 8'd0;
      err_count <= 8'd0;
      pass      <= 1'b0;
      lockup    <= 1'b0;
      done      <= 1'b0;
`ifdef LFSR_CHK_RESYNC_EN
      consec    <= 2'd0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tap0_q    <= tap0;
            tap1_q    <= tap1;
            seq_q     <= seq_num;
            err_count <= 8'd0;
            pass      <= 1'b0;
            lockup    <= 1'b0;
            cnt       <= 8'd0;
`ifdef LFSR_CHK_RESYNC_EN
            consec    <= 2'd0;
`endif
            state     <= SEED;
          end
        end
        SEED: begin
          if (acc) begin
            pred <= lfsr_next(in_if.in_data, tap0_q, tap1_q);
            if (in_if.in_data == 8'h00) begin
              lockup <= 1'b1;
              pass   <= 1'b0;
              done   <= 1'b1;
              state  <= DONE;
            end else if (seq_q == 8'd0) begin
              pass   <= 1'b1;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              state  <= CHECK;
            end
          end
        end
        CHECK: begin
          if (acc) begin
            err_count <= err_nxt;
`ifdef LFSR_CHK_RESYNC_EN
            if (!mism) begin
              consec <= 2'd0;
              pred   <= lfsr_next(pred, tap0_q, tap1_q);
            end else if (consec == 2'd2) begin
              consec <= 2'd0;
              pred   <= lfsr_next(in_if.in_data, tap0_q, tap1_q);
            end else begin
              consec <= consec + 2'd1;
              pred   <= lfsr_next(pred, tap0_q, tap1_q);
            end
`else
            pred <= lfsr_next(pred, tap0_q, tap1_q);
`endif
            cnt <= cnt_nxt;
            if (cnt_nxt == seq_q) begin
              pass  <= (err_nxt == 8'd0) && !lockup;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed and randomized bench for lfsr_checker. An arithmetic reference
// model of the LFSR rules produces the expected error count, lock-up and
// pass result for each run.
module tb_lfsr_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] tap0 = 3'd0, tap1 = 3'd0;
  logic [7:0] seq_num = 8'd0;
  logic       busy, done, pass, lockup;
  logic [7:0] err_count;

  lfsr_checker_if bus();

  lfsr_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tap0(tap0), .tap1(tap1),
    .seq_num(seq_num), .in_if(bus.slave), .busy(busy), .done(done),
    .pass(pass), .lockup(lockup), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [7:0] w[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_next(input int x, input int a, input int b);
    return ((x * 2) % 256) + ((((x >> a) ^ (x >> b))) % 2);
  endfunction

  // Reference: walk the word list with a free-running prediction.
  task automatic model(input int a, input int b, input int sn,
                       output int e_err, output bit e_lock, output bit e_pass,
                       output int e_acc);
    int p, run;
    e_err = 0; run = 0;
    e_lock = (w[0] == 8'h00);
    if (e_lock || sn == 0) e_acc = 1; else e_acc = sn + 1;
    p = model_next(w[0], a, b);
    if (!e_lock) begin
      for (int i = 1; i <= sn; i++) begin
        if (int'(w[i]) != p) begin
          if (e_err < 255) e_err++;
          run++;
`ifdef LFSR_CHK_RESYNC_EN
          if (run == 3) begin
            run = 0;
            p = model_next(w[i], a, b);
            continue;
          end
`endif
        end else run = 0;
        p = model_next(p, a, b);
      end
    end
    e_pass = !e_lock && (e_err == 0);
  endtask

  task automatic run(input string tag, input logic [2:0] a, input logic [2:0] b,
                     input logic [7:0] sn, input bit gaps, input bit poke);
    int e_err, e_acc, acc, cyc;
    bit e_lock, e_pass, hold, seen, poked;
    model(a, b, sn, e_err, e_lock, e_pass, e_acc);
    @(negedge clk);
    start = 1'b1; tap0 = a; tap1 = b; seq_num = sn;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy_at_seed"}, busy, 1);
    chk({tag, " ready_at_seed"}, bus.in_ready, 1);
    acc = 0; cyc = 0; seen = 0; poked = 0;
    while (!seen && cyc < 400) begin
      bus.in_valid = (acc < w.size()) && (!gaps || $urandom_range(0, 2) != 0);
      bus.in_data  = (acc < w.size()) ? w[acc] : 8'h00;
      start = poke && !poked && (acc == 2);
      if (start) begin
        poked = 1; tap0 = 3'd0; tap1 = 3'd0; seq_num = 8'd1;
      end else begin
        tap0 = a; tap1 = b; seq_num = sn;
      end
      hold = bus.in_valid && bus.in_ready;
      @(negedge clk);
      cyc++;
      if (hold) acc++;
      bus.in_valid = 1'b0;
      start = 1'b0;
      if (done) begin
        seen = 1;
        chk({tag, " done_after_last_accept"}, hold, 1);
        chk({tag, " accepts"}, acc, e_acc);
        chk({tag, " err_count"}, err_count, e_err);
        chk({tag, " lockup"}, lockup, e_lock);
        chk({tag, " pass_with_done"}, pass, e_pass);
        chk({tag, " busy_in_done"}, busy, 0);
      end else if (acc >= e_acc && !hold) begin
        chk({tag, " done_late"}, done, 1);
        cyc = 400;
      end
    end
    if (!seen) chk({tag, " done_timeout"}, seen, 1);
    @(negedge clk);
    chk({tag, " done_one_cycle"}, done, 0);
    chk({tag, " pass_held"}, pass, e_pass);
    chk({tag, " ready_idle"}, bus.in_ready, 0);
  endtask

  task automatic make_stream(input int seed, input int a, input int b, input int n);
    int x;
    w.delete();
    x = seed;
    for (int i = 0; i < n; i++) begin
      w.push_back(8'(x));
      x = model_next(x, a, b);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    #12;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset pass", pass, 0);
    chk("reset lockup", lockup, 0);
    chk("reset err", err_count, 0);
    chk("reset ready", bus.in_ready, 0);
    rst_n = 1'b1;

    w = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};
    run("nominal", 3'd7, 3'd5, 8'd5, 0, 0);
    run("nominal_gaps", 3'd7, 3'd5, 8'd5, 1, 0);
    run("start_in_check", 3'd7, 3'd5, 8'd5, 0, 1);

    w = '{8'h01, 8'h02, 8'h04, 8'h09, 8'h10, 8'h20};
    run("corrupt", 3'd7, 3'd5, 8'd5, 0, 0);

    w = '{8'h00, 8'h01, 8'h02};
    run("lockup", 3'd7, 3'd5, 8'd5, 0, 0);

    w = '{8'h5A, 8'h11};
    run("seq0", 3'd7, 3'd5, 8'd0, 0, 0);

    w = '{8'h01, 8'h40, 8'h80, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};
    run("sync_loss", 3'd7, 3'd5, 8'd8, 0, 0);

    for (int r = 0; r < 8; r++) begin
      int a, b, sn;
      a  = $urandom_range(0, 7);
      b  = $urandom_range(0, 7);
      sn = $urandom_range(1, 20);
      make_stream($urandom_range(1, 255), a, b, sn + 1);
      for (int i = 1; i <= sn; i++)
        if ($urandom_range(0, 5) == 0) w[i] = w[i] ^ 8'($urandom_range(1, 255));
      run($sformatf("rand%0d", r), 3'(a), 3'(b), 8'(sn), 1, 0);
    end

    // Abort mid-CHECK: outputs clear at once and no done follows.
    make_stream(8'h01, 7, 5, 9);
    w[2] = 8'h33;
    @(negedge clk);
    start = 1'b1; tap0 = 3'd7; tap1 = 3'd5; seq_num = 8'd8;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.in_data = w[i];
      @(negedge clk);
    end
    chk("abort pre err", err_count, 1);
    chk("abort pre busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort busy", busy, 0);
    chk("abort err", err_count, 0);
    chk("abort ready", bus.in_ready, 0);
    chk("abort pass", pass, 0);
    chk("abort lockup", lockup, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort no done", done, 0);
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
